// File: rtl/mips_multicycle.sv
// mips_multicycle
// ---------------------------------------------------------------------------
// Multi-cycle MIPS core with a single shared instruction/data memory port.
// Subset: add/sub/and/or/slt, addi, lw, sw, beq, bne, j. Anything else, and
// any misaligned lw/sw address, parks the core in a sticky HALT state that
// only reset leaves.
//
// Parameters
//   RESET_PC     PC loaded on reset
//   ADDR_W       memory byte-address width (4..32); mem_addr = addr[ADDR_W-1:0]
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   mem_req      memory request valid
//   mem_we       1 = write (sw), 0 = read
//   mem_addr     word-aligned byte address
//   mem_wdata    store data
//   mem_rdata    read data, sampled in the cycle mem_ready = 1
//   mem_ready    memory ready
//   halted       sticky halt indicator
//   cycle_cnt    cycles spent outside HALT      (MIPS_PERF_CNT_EN only)
//   instret_cnt  retired instructions           (MIPS_PERF_CNT_EN only)
//   dbg_state    current FSM state
//
// Handshake: a transfer completes on the rising edge where mem_req && mem_ready.
// While mem_req = 1 and mem_ready = 0, mem_req/mem_we/mem_addr/mem_wdata hold
// their values. mem_ready is ignored whenever mem_req = 0. Asserting reset
// drops mem_req at once, abandoning any pending request.
//
// Optional feature macro: MIPS_PERF_CNT_EN adds cycle_cnt and instret_cnt.
// ---------------------------------------------------------------------------
module mips_multicycle #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              halted,
`ifdef MIPS_PERF_CNT_EN
  output logic [31:0]       cycle_cnt,
  output logic [31:0]       instret_cnt,
`endif
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] ir, ir_nxt;
  logic [31:0] a, a_nxt;
  logic [31:0] b, b_nxt;
  logic [31:0] aluout, alu_nxt;
  logic [31:0] mdr, mdr_nxt;
  logic [31:0] rf [32];

  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        retire;

  // instruction fields
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_sx;
  logic        unused_shamt;

  assign op           = ir[31:26];
  assign rs           = ir[25:21];
  assign rt           = ir[20:16];
  assign rd           = ir[15:11];
  assign funct        = ir[5:0];
  assign imm_sx       = {{16{ir[15]}}, ir[15:0]};
  assign unused_shamt = ^ir[10:6];

  logic is_r, is_addi, is_lw, is_sw, is_beq, is_bne, is_j, legal;

  always_comb begin
    is_r = 1'b0;
    if (op == 6'h00) begin
      case (funct)
        6'h20, 6'h22, 6'h24, 6'h25, 6'h2A: is_r = 1'b1;
        default:                           is_r = 1'b0;
      endcase
    end
  end

  assign is_addi = (op == 6'h08);
  assign is_lw   = (op == 6'h23);
  assign is_sw   = (op == 6'h2B);
  assign is_beq  = (op == 6'h04);
  assign is_bne  = (op == 6'h05);
  assign is_j    = (op == 6'h02);
  assign legal   = is_r | is_addi | is_lw | is_sw | is_beq | is_bne | is_j;

  // register file reads; $0 always reads zero
  logic [31:0] rf_rs, rf_rt;
  assign rf_rs = (rs == 5'd0) ? 32'h0 : rf[rs];
  assign rf_rt = (rt == 5'd0) ? 32'h0 : rf[rt];

  // ALU: R-type by funct, otherwise addi
  logic [31:0] alu_res, ea;
  assign ea = a + imm_sx;

  always_comb begin
    alu_res = a + imm_sx;
    if (is_r) begin
      case (funct)
        6'h20:   alu_res = a + b;
        6'h22:   alu_res = a - b;
        6'h24:   alu_res = a & b;
        6'h25:   alu_res = a | b;
        6'h2A:   alu_res = {31'h0, ($signed(a) < $signed(b))};
        default: alu_res = a + b;
      endcase
    end
  end

  logic handshake;
  assign handshake = mem_req && mem_ready;

  // next-state and datapath updates
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    ir_nxt    = ir;
    a_nxt     = a;
    b_nxt     = b;
    alu_nxt   = aluout;
    mdr_nxt   = mdr;
    rf_we     = 1'b0;
    rf_waddr  = 5'd0;
    rf_wdata  = 32'h0;
    retire    = 1'b0;
    case (state)
      S_FETCH: begin
        if (handshake) begin
          ir_nxt    = mem_rdata;
          pc_nxt    = pc + 32'd4;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        a_nxt     = rf_rs;
        b_nxt     = rf_rt;
        state_nxt = legal ? S_EXEC : S_HALT;
      end
      S_EXEC: begin
        if (is_r || is_addi) begin
          alu_nxt   = alu_res;
          state_nxt = S_WB;
        end else if (is_lw || is_sw) begin
          alu_nxt   = ea;
          state_nxt = (ea[1:0] != 2'b00) ? S_HALT : S_MEM;
        end else if (is_beq || is_bne) begin
          // pc already points past the branch
          if ((a == b) == is_beq) pc_nxt = pc + {imm_sx[29:0], 2'b00};
          retire    = 1'b1;
          state_nxt = S_FETCH;
        end else if (is_j) begin
          pc_nxt    = {pc[31:28], ir[25:0], 2'b00};
          retire    = 1'b1;
          state_nxt = S_FETCH;
        end else begin
          state_nxt = S_HALT;
        end
      end
      S_MEM: begin
        if (handshake) begin
          if (is_lw) begin
            mdr_nxt   = mem_rdata;
            state_nxt = S_WB;
          end else begin
            retire    = 1'b1;
            state_nxt = S_FETCH;
          end
        end
      end
      S_WB: begin
        rf_we     = 1'b1;
        rf_waddr  = is_r ? rd : rt;
        rf_wdata  = is_lw ? mdr : aluout;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_HALT;
    endcase
  end

  // Bus outputs are registered from the next state so they come straight
  // off flops and line up with the state they belong to. Waiting leaves
  // state/pc/aluout unchanged, which keeps the bus stable automatically.
  logic              req_nxt, we_nxt, halted_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [31:0]       wdata_nxt;

  always_comb begin
    req_nxt    = (state_nxt == S_FETCH) || (state_nxt == S_MEM);
    we_nxt     = (state_nxt == S_MEM) && is_sw;
    wdata_nxt  = ((state_nxt == S_MEM) && is_sw) ? b_nxt : 32'h0;
    halted_nxt = (state_nxt == S_HALT);
    addr_nxt   = '0;
    if (state_nxt == S_FETCH)    addr_nxt = pc_nxt[ADDR_W-1:0];
    else if (state_nxt == S_MEM) addr_nxt = alu_nxt[ADDR_W-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_FETCH;
      pc        <= RESET_PC;
      ir        <= 32'h0;
      a         <= 32'h0;
      b         <= 32'h0;
      aluout    <= 32'h0;
      mdr       <= 32'h0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'h0;
      halted    <= 1'b0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      ir        <= ir_nxt;
      a         <= a_nxt;
      b         <= b_nxt;
      aluout    <= alu_nxt;
      mdr       <= mdr_nxt;
      mem_req   <= req_nxt;
      mem_we    <= we_nxt;
      mem_addr  <= addr_nxt;
      mem_wdata <= wdata_nxt;
      halted    <= halted_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'h0;
    end else if (rf_we && (rf_waddr != 5'd0)) begin
      rf[rf_waddr] <= rf_wdata;
    end
  end

`ifdef MIPS_PERF_CNT_EN
  // retire is only raised outside HALT, so both counters freeze there
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_cnt   <= 32'h0;
      instret_cnt <= 32'h0;
    end else begin
      if (state != S_HALT) cycle_cnt <= cycle_cnt + 32'd1;
      if (retire)          instret_cnt <= instret_cnt + 32'd1;
    end
  end
`endif

  assign dbg_state = state;

endmodule

// File: doc/mips_multicycle.md
# mips_multicycle

Multi-cycle MIPS core that replaces the single-cycle top. It keeps the same instruction subset plus `bne` and `j`, and runs it through a state machine with one shared instruction/data memory port. The memory port uses a variable-latency req/ready handshake, so IMEM/DMEM can be swapped for slower memories. Illegal instructions and misaligned accesses stop the core in a sticky halt state.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `ADDR_W`, 16, memory byte-address width (4..32); `mem_addr` = PC/effective address bits [ADDR_W-1:0].

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `mem_req`  out  1  memory request valid.
- `mem_we`  out  1  1 = write (sw), 0 = read.
- `mem_addr`  out  ADDR_W  byte address, always word aligned.
- `mem_wdata`  out  32  store data.
- `mem_rdata`  in  32  read data, valid in the cycle `mem_ready`=1.
- `mem_ready`  in  1  transfer completes on the edge where `mem_req`&&`mem_ready`.
- `halted`  out  1  sticky halt indicator.
- `cycle_cnt`  out  32  present only with MIPS_PERF_CNT_EN.
- `instret_cnt`  out  32  present only with MIPS_PERF_CNT_EN.

## Operation
- Supported instructions:
  - R-type `add/sub/and/or/slt`, func 0x20/0x22/0x24/0x25/0x2A.
  - `addi` 0x08, `lw` 0x23, `sw` 0x2B, `beq` 0x04, `bne` 0x05, `j` 0x02.
  - Any other op/func: enter HALT.
- Internal state: 32x32 register file with $0 reads 0 and writes to it ignored. Also PC, IR, A, B, ALUOut and MDR registers.
- FSM states: FETCH, DECODE, EXEC, MEM, WB, HALT.
  - FETCH: `mem_req`=1, `we`=0, addr=PC. On ready: IR<=rdata, PC<=PC+4, go to DECODE.
  - DECODE: A<=R[rs], B<=R[rt]. Illegal instruction goes to HALT.
  - EXEC, R-type/addi: ALUOut<=result, go to WB.
  - EXEC, lw/sw: ALUOut<=A+sext(imm), go to MEM; address bits[1:0]≠0 go to HALT instead.
  - EXEC, beq/bne: if taken, PC<=PC+(sext(imm)<<2). Go to FETCH.
  - EXEC, j: PC<={PC[31:28],target,2'b00}. Go to FETCH.
  - MEM: `mem_req`=1, addr=ALUOut, `we`=1 for sw with wdata=B. On ready: lw captures MDR and goes to WB; sw goes to FETCH.
  - WB: write R[rd] for R-type, or R[rt] with ALUOut (addi) or MDR (lw). Go to FETCH.
  - HALT: terminal. `halted`=1, `mem_req`=0. Left only via reset.
- Arithmetic: 32-bit, wrap on overflow, no exceptions. `slt` is signed. `addi` uses sign-extended imm16.

## Timing
- Reset (async assert, sync release) sets state=FETCH, PC=RESET_PC and all registers to 0.
- Outputs under reset: `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `halted`=0, counters=0.
- `mem_req`/`mem_we`/`mem_addr`/`mem_wdata` are registered-state decodes. They are held stable while `mem_req`=1 && !`mem_ready`.
- `mem_ready` is ignored when `mem_req`=0.
- Cycles per instruction with zero-wait memory (ready=1 in the first request cycle):
  - R-type/addi 4, lw 5, sw 4, beq/bne/j 3.
  - Each wait cycle adds 1.
- `mem_req` drops for at least one cycle between FETCH and MEM. lw/sw are never back-to-back with a fetch.
- Reset during a pending request drops `mem_req` immediately; the memory must tolerate abandonment.
- PC wraps modulo 2^32. `mem_addr` truncates to ADDR_W bits.

## Configuration
- `MIPS_PERF_CNT_EN` defined:
  - `cycle_cnt` increments every cycle while `reset` is deasserted and the state is not HALT.
  - `instret_cnt` increments on each instruction's final state exit (WB, sw MEM, branch/jump EXEC).
  - Both counters wrap at 2^32 and freeze in HALT.
- Undefined: both ports and counters are absent.

## Test plan
- Reset, RESET_PC=0x40, ready tied 1 -> first `mem_addr`=0x40 one cycle after release; `halted`=0.
- Program `addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2; slt $4,$2,$1`, zero-wait:
  - Final values: $3=2, $4=1.
  - Completes in 16 cycles; `instret_cnt`=4.
- `sw $3,8($0); lw $5,8($0)` with ready delayed 3 cycles per request:
  - $5=2; sw takes 10 cycles, lw 11.
  - `mem_addr`/`mem_wdata` stay stable while waiting.
- Control flow:
  - `beq` taken with imm=-1 loops to itself; PC sequence repeats every 3 cycles.
  - `bne` with equal operands falls through to PC+4.
  - `j 0x100` -> next fetch addr 0x400.
- Halt cases:
  - Opcode 0x3F -> `halted`=1 after DECODE.
  - `lw` at address 0x6 -> `halted`=1 after EXEC with no `mem_req`.
  - In both cases counters freeze.
- Reset asserted mid-FETCH with ready held low -> `mem_req`=0 asynchronously; after release the fetch restarts at RESET_PC.
